// File: rtl/gem_tx_link_seq.sv
// Bring-up and run-time sequencer for the GEM trigger fiber transmitter: waits for PLL lock and
// TX phase alignment, holds a comma window, then releases live data or PRBS; re-sequences on loss.
module gem_tx_link_seq #(
    parameter int unsigned COMMA_CYCLES = 256,
    parameter int unsigned SYNC_TIMEOUT = 65535
) (
    input  logic       TRG_CLK80,
    input  logic       TRG_TXRESETDONE,
    input  logic       TRG_TX_PLL_LOCK,
    input  logic       TX_SYNC_DONE,
    input  logic       PRBS_REQ,
    input  logic       FORCE_RESYNC,
    output logic       TRG_RST,
    output logic       ENA_TEST_PAT,
    output logic       LINK_UP,
    output logic [2:0] STATE,
    output logic       SYNC_TIMEOUT_ERR,
    output logic [7:0] RESYNC_CNT
);

    localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] ST_COMMA     = 3'd2;
    localparam logic [2:0] ST_PRBS      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

    localparam logic [15:0] COMMA_LAST = 16'(COMMA_CYCLES - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_TIMEOUT - 1);

    logic        r_lock_meta;
    logic        r_lock_s;
    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic        r_trg_rst;
    logic        r_ena_test_pat;
    logic        r_link_up;
    logic        r_sync_err;
    logic [7:0]  r_resync_cnt;

    logic [2:0]  w_state_d;
    logic [15:0] w_timer_d;
    logic        w_resync;
    logic        w_in_link;
    logic        w_state_change;
    logic        w_enter_error;
    logic [7:0]  w_resync_cnt_d;

    // Lock comes from the PLL domain; two flops before it is used.
    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= TRG_TX_PLL_LOCK;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_in_link = (r_state == ST_COMMA) || (r_state == ST_PRBS) || (r_state == ST_RUN);

    always_comb begin
        w_state_d = r_state;
        w_resync  = 1'b0;
        if (r_state == ST_WAIT_LOCK) begin
            if (r_lock_s) begin
                w_state_d = ST_WAIT_SYNC;
            end
        end else if (r_state > ST_ERROR) begin
            w_state_d = ST_WAIT_LOCK;
        end else if (!r_lock_s || FORCE_RESYNC) begin
            w_state_d = ST_WAIT_LOCK;
            w_resync  = 1'b1;
        end else if (w_in_link && !TX_SYNC_DONE) begin
            w_state_d = ST_WAIT_SYNC;
            w_resync  = 1'b1;
        end else begin
            case (r_state)
                ST_WAIT_SYNC: begin
                    // Sync arriving on the timeout edge takes precedence over the error.
                    if (TX_SYNC_DONE) begin
                        w_state_d = ST_COMMA;
                    end else if (r_timer == SYNC_LAST) begin
                        w_state_d = ST_ERROR;
                    end
                end
                ST_COMMA: begin
                    if (r_timer == COMMA_LAST) begin
                        w_state_d = PRBS_REQ ? ST_PRBS : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (PRBS_REQ) begin
                        w_state_d = ST_COMMA;
                    end
                end
                ST_PRBS: begin
                    if (!PRBS_REQ) begin
                        w_state_d = ST_COMMA;
                    end
                end
                default: begin
                    w_state_d = r_state;
                end
            endcase
        end
    end

    assign w_state_change = (w_state_d != r_state);
    assign w_enter_error  = (w_state_d == ST_ERROR) && (r_state != ST_ERROR);

    always_comb begin
        w_timer_d = r_timer;
        if (w_state_change) begin
            w_timer_d = '0;
        end else if ((r_state == ST_WAIT_SYNC) || (r_state == ST_COMMA)) begin
            w_timer_d = r_timer + 16'd1;
        end
    end

    assign w_resync_cnt_d = (w_resync && (r_resync_cnt != 8'hFF)) ? r_resync_cnt + 8'd1
                                                                  : r_resync_cnt;

    // Outputs are decoded from the next state so they move on the same edge as STATE.
    always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
        if (!TRG_TXRESETDONE) begin
            r_state        <= ST_WAIT_LOCK;
            r_timer        <= '0;
            r_trg_rst      <= 1'b1;
            r_ena_test_pat <= 1'b0;
            r_link_up      <= 1'b0;
            r_sync_err     <= 1'b0;
            r_resync_cnt   <= '0;
        end else begin
            r_state        <= w_state_d;
            r_timer        <= w_timer_d;
            r_trg_rst      <= !((w_state_d == ST_PRBS) || (w_state_d == ST_RUN));
            r_ena_test_pat <= (w_state_d == ST_PRBS);
            r_link_up      <= (w_state_d == ST_RUN);
            r_sync_err     <= r_sync_err | w_enter_error;
            r_resync_cnt   <= w_resync_cnt_d;
        end
    end

    assign TRG_RST          = r_trg_rst;
    assign ENA_TEST_PAT     = r_ena_test_pat;
    assign LINK_UP          = r_link_up;
    assign STATE            = r_state;
    assign SYNC_TIMEOUT_ERR = r_sync_err;
    assign RESYNC_CNT       = r_resync_cnt;

endmodule
